// File: rtl/mem2axi_bridge_if.sv
// Interfaces joining the bridge: a request/reply memory port and AXI-lite
// style channels.
interface Mem_ift #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                    w_request_valid;
    logic                    w_request_ready;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wmask;
    logic                    w_reply_valid;
    logic                    w_reply_ready;
    logic [1:0]              bresp;
    logic                    r_request_valid;
    logic                    r_request_ready;
    logic [ADDR_WIDTH-1:0]   raddr;
    logic                    r_reply_valid;
    logic                    r_reply_ready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport Slave (
        input  w_request_valid, waddr, wdata, wmask, w_reply_ready,
        input  r_request_valid, raddr, r_reply_ready,
        output w_request_ready, w_reply_valid, bresp,
        output r_request_ready, r_reply_valid, rdata, rresp
    );

    modport Master (
        output w_request_valid, waddr, wdata, wmask, w_reply_ready,
        output r_request_valid, raddr, r_reply_ready,
        input  w_request_ready, w_reply_valid, bresp,
        input  r_request_ready, r_reply_valid, rdata, rresp
    );
endinterface

interface Axi_ift #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                    w_addr_request_valid;
    logic                    w_addr_request_ready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    w_data_request_valid;
    logic                    w_data_request_ready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    w_reply_valid;
    logic                    w_reply_ready;
    logic [1:0]              bresp;
    logic                    r_request_valid;
    logic                    r_request_ready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    r_reply_valid;
    logic                    r_reply_ready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport Master (
        output w_addr_request_valid, awaddr, w_data_request_valid, wdata, wstrb,
        output w_reply_ready, r_request_valid, araddr, r_reply_ready,
        input  w_addr_request_ready, w_data_request_ready, w_reply_valid, bresp,
        input  r_request_ready, r_reply_valid, rdata, rresp
    );

    modport Slave (
        input  w_addr_request_valid, awaddr, w_data_request_valid, wdata, wstrb,
        input  w_reply_ready, r_request_valid, araddr, r_reply_ready,
        output w_addr_request_ready, w_data_request_ready, w_reply_valid, bresp,
        output r_request_ready, r_reply_valid, rdata, rresp
    );
endinterface

// File: rtl/mem2axi_bridge.sv
// Memory request/reply port to AXI-lite bridge with independent AW/W queues,
// bounded outstanding writes/reads and optional read-after-write ordering.
module mem2axi_bridge #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int WQ_DEPTH   = 4,
    parameter int MAX_WR_OUT = 8,
    parameter int MAX_RD_OUT = 4,
    parameter bit RAW_ORDER  = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    Mem_ift.Slave  mem_ift,
    Axi_ift.Master axi_ift,
    output logic   err
);

    localparam int IDX_W  = $clog2(WQ_DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] MAX_WR = CNT_W'(MAX_WR_OUT);
    localparam logic [CNT_W-1:0] MAX_RD = CNT_W'(MAX_RD_OUT);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    if ($bits(mem_ift.waddr) != ADDR_WIDTH || $bits(axi_ift.awaddr) != ADDR_WIDTH) begin : g_addr_chk
        $fatal(1, "mem2axi_bridge: interface ADDR_WIDTH differs from ADDR_WIDTH");
    end
    if ($bits(mem_ift.wdata) != DATA_WIDTH || $bits(axi_ift.wdata) != DATA_WIDTH) begin : g_data_chk
        $fatal(1, "mem2axi_bridge: interface DATA_WIDTH differs from DATA_WIDTH");
    end
    if (WQ_DEPTH < 2 || (WQ_DEPTH & (WQ_DEPTH - 1)) != 0) begin : g_depth_chk
        $fatal(1, "mem2axi_bridge: WQ_DEPTH must be a power of two >= 2");
    end
    if (MAX_WR_OUT < 1 || MAX_WR_OUT > 255 || MAX_RD_OUT < 1 || MAX_RD_OUT > 255) begin : g_out_chk
        $fatal(1, "mem2axi_bridge: outstanding limits must be within 1..255");
    end

    logic [ADDR_WIDTH-1:0] awq_mem   [WQ_DEPTH];
    logic [DATA_WIDTH-1:0] wq_data_mem [WQ_DEPTH];
    logic [STRB_W-1:0]     wq_strb_mem [WQ_DEPTH];

    ptr_t aw_wptr_q, aw_wptr_d, aw_rptr_q, aw_rptr_d;
    ptr_t w_wptr_q,  w_wptr_d,  w_rptr_q,  w_rptr_d;
    cnt_t wr_cnt_q,  wr_cnt_d,  rd_cnt_q,  rd_cnt_d;
    logic err_q, err_d;

    logic awq_full, awq_empty, wq_full, wq_empty;
    logic wr_ready, rd_ok;
    logic wr_push, aw_pop, w_pop, b_hs, ar_hs, r_hs;

    assign awq_empty = (aw_wptr_q == aw_rptr_q);
    assign awq_full  = (aw_wptr_q[IDX_W] != aw_rptr_q[IDX_W]) &&
                       (aw_wptr_q[IDX_W-1:0] == aw_rptr_q[IDX_W-1:0]);
    assign wq_empty  = (w_wptr_q == w_rptr_q);
    assign wq_full   = (w_wptr_q[IDX_W] != w_rptr_q[IDX_W]) &&
                       (w_wptr_q[IDX_W-1:0] == w_rptr_q[IDX_W-1:0]);

    // Write acceptance looks only at registered state so it never waits on the interconnect.
    assign wr_ready = !awq_full && !wq_full && (wr_cnt_q < MAX_WR);
    assign rd_ok    = (rd_cnt_q < MAX_RD) && (!RAW_ORDER || wr_cnt_q == '0);

    assign wr_push = mem_ift.w_request_valid && wr_ready;
    assign aw_pop  = !awq_empty && axi_ift.w_addr_request_ready;
    assign w_pop   = !wq_empty && axi_ift.w_data_request_ready;
    assign b_hs    = axi_ift.w_reply_valid && mem_ift.w_reply_ready;
    assign ar_hs   = mem_ift.r_request_valid && axi_ift.r_request_ready && rd_ok;
    assign r_hs    = axi_ift.r_reply_valid && mem_ift.r_reply_ready;

    assign mem_ift.w_request_ready    = wr_ready;
    assign axi_ift.w_addr_request_valid = !awq_empty;
    assign axi_ift.awaddr             = awq_mem[aw_rptr_q[IDX_W-1:0]];
    assign axi_ift.w_data_request_valid = !wq_empty;
    assign axi_ift.wdata              = wq_data_mem[w_rptr_q[IDX_W-1:0]];
    assign axi_ift.wstrb              = wq_strb_mem[w_rptr_q[IDX_W-1:0]];

    assign mem_ift.w_reply_valid = axi_ift.w_reply_valid;
    assign mem_ift.bresp         = axi_ift.bresp;
    assign axi_ift.w_reply_ready = mem_ift.w_reply_ready;

    assign axi_ift.r_request_valid = mem_ift.r_request_valid && rd_ok;
    assign mem_ift.r_request_ready = axi_ift.r_request_ready && rd_ok;
    assign axi_ift.araddr          = mem_ift.raddr;

    assign mem_ift.r_reply_valid = axi_ift.r_reply_valid;
    assign mem_ift.rdata         = axi_ift.rdata;
    assign mem_ift.rresp         = axi_ift.rresp;
    assign axi_ift.r_reply_ready = mem_ift.r_reply_ready;

    assign err = err_q;

    always_comb begin
        // NOTE: every variable gets its default first, so no path leaves one unassigned and infers a latch.
        aw_wptr_d = aw_wptr_q;
        aw_rptr_d = aw_rptr_q;
        w_wptr_d  = w_wptr_q;
        w_rptr_d  = w_rptr_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_d     = err_q;

        if (wr_push) begin
            aw_wptr_d = aw_wptr_q + ptr_t'(1);
            w_wptr_d  = w_wptr_q + ptr_t'(1);
        end
        if (aw_pop) aw_rptr_d = aw_rptr_q + ptr_t'(1);
        if (w_pop)  w_rptr_d  = w_rptr_q + ptr_t'(1);

        // A reply with nothing outstanding is a protocol error; the count saturates at zero.
        if (wr_push && !b_hs)                        wr_cnt_d = wr_cnt_q + cnt_t'(1);
        else if (!wr_push && b_hs && wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - cnt_t'(1);
        if (b_hs && wr_cnt_q == '0) err_d = 1'b1;

        if (ar_hs && !r_hs)                        rd_cnt_d = rd_cnt_q + cnt_t'(1);
        else if (!ar_hs && r_hs && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - cnt_t'(1);
        if (r_hs && rd_cnt_q == '0) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            aw_wptr_q <= '0;
            aw_rptr_q <= '0;
            w_wptr_q  <= '0;
            w_rptr_q  <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            aw_wptr_q <= aw_wptr_d;
            aw_rptr_q <= aw_rptr_d;
            w_wptr_q  <= w_wptr_d;
            w_rptr_q  <= w_rptr_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_q     <= err_d;
        end
    end

    // NOTE: queue storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_push) begin
            awq_mem[aw_wptr_q[IDX_W-1:0]]    <= mem_ift.waddr;
            wq_data_mem[w_wptr_q[IDX_W-1:0]] <= mem_ift.wdata;
            wq_strb_mem[w_wptr_q[IDX_W-1:0]] <= mem_ift.wmask;
        end
    end

endmodule

// File: tb/tb_mem2axi_bridge.sv
// Directed bench: dut_a uses default parameters, dut_b has MAX_WR_OUT=2 and
// reads independent of writes.
module tb_mem2axi_bridge;

    logic clk = 1'b0;
    logic rst;
    logic err_a, err_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    Mem_ift mem_a ();
    Axi_ift axi_a ();
    Mem_ift mem_b ();
    Axi_ift axi_b ();

    mem2axi_bridge dut_a (
        .clk     (clk),
        .rst     (rst),
        .mem_ift (mem_a),
        .axi_ift (axi_a),
        .err     (err_a)
    );

    mem2axi_bridge #(
        .MAX_WR_OUT (2),
        .RAW_ORDER  (1'b0)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .mem_ift (mem_b),
        .axi_ift (axi_b),
        .err     (err_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic idle_all();
        mem_a.w_request_valid = 1'b0; mem_a.waddr = '0; mem_a.wdata = '0; mem_a.wmask = '0;
        mem_a.w_reply_ready = 1'b0; mem_a.r_request_valid = 1'b0; mem_a.raddr = '0;
        mem_a.r_reply_ready = 1'b0;
        axi_a.w_addr_request_ready = 1'b0; axi_a.w_data_request_ready = 1'b0;
        axi_a.w_reply_valid = 1'b0; axi_a.bresp = '0; axi_a.r_request_ready = 1'b0;
        axi_a.r_reply_valid = 1'b0; axi_a.rdata = '0; axi_a.rresp = '0;
        mem_b.w_request_valid = 1'b0; mem_b.waddr = '0; mem_b.wdata = '0; mem_b.wmask = '0;
        mem_b.w_reply_ready = 1'b0; mem_b.r_request_valid = 1'b0; mem_b.raddr = '0;
        mem_b.r_reply_ready = 1'b0;
        axi_b.w_addr_request_ready = 1'b0; axi_b.w_data_request_ready = 1'b0;
        axi_b.w_reply_valid = 1'b0; axi_b.bresp = '0; axi_b.r_request_ready = 1'b0;
        axi_b.r_reply_valid = 1'b0; axi_b.rdata = '0; axi_b.rresp = '0;
    endtask

    task automatic drive_wr_a(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] mask);
        mem_a.w_request_valid = 1'b1;
        mem_a.waddr = addr;
        mem_a.wdata = data;
        mem_a.wmask = mask;
    endtask

    task automatic drive_wr_b(input logic [63:0] addr, input logic [63:0] data);
        mem_b.w_request_valid = 1'b1;
        mem_b.waddr = addr;
        mem_b.wdata = data;
        mem_b.wmask = 8'hFF;
    endtask

    initial begin
        // Reset held 3 cycles with traffic on every input.
        idle_all();
        rst = 1'b1;
        drive_wr_a(64'h900, 64'h9, 8'hFF);
        drive_wr_b(64'h900, 64'h9);
        mem_a.r_request_valid = 1'b1;
        axi_a.r_request_ready = 1'b1;
        axi_a.w_reply_valid = 1'b1;
        mem_a.w_reply_ready = 1'b1;
        step(3);
        idle_all();
        rst = 1'b0;
        #1;
        check("rst_aw_valid", 64'(axi_a.w_addr_request_valid), 64'd0);
        check("rst_w_valid", 64'(axi_a.w_data_request_valid), 64'd0);
        check("rst_ar_valid", 64'(axi_a.r_request_valid), 64'd0);
        check("rst_wr_ready", 64'(mem_a.w_request_ready), 64'd1);
        check("rst_err", 64'(err_a), 64'd0);
        check("rst_wr_cnt", 64'(dut_a.wr_cnt_q), 64'd0);
        check("rst_rd_cnt", 64'(dut_a.rd_cnt_q), 64'd0);
        check("rst_b_wr_ready", 64'(mem_b.w_request_ready), 64'd1);
        check("rst_b_err", 64'(err_b), 64'd0);

        // Fill and drain with AXI readies low.
        for (int i = 0; i < 4; i++) begin
            drive_wr_a(64'h100 + 64'(8 * i), 64'(i), 8'h01 << i);
            #1;
            check("fill_ready", 64'(mem_a.w_request_ready), 64'd1);
            step();
        end
        drive_wr_a(64'h120, 64'd4, 8'h10);
        #1;
        check("fill_full_ready", 64'(mem_a.w_request_ready), 64'd0);
        check("fill_aw_valid", 64'(axi_a.w_addr_request_valid), 64'd1);
        check("fill_aw_head", axi_a.awaddr, 64'h100);
        step(2);
        #1;
        check("fill_still_full", 64'(mem_a.w_request_ready), 64'd0);
        check("fill_wr_cnt", 64'(dut_a.wr_cnt_q), 64'd4);
        mem_a.w_request_valid = 1'b0;
        axi_a.w_addr_request_ready = 1'b1;
        axi_a.w_data_request_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("drain_aw_valid", 64'(axi_a.w_addr_request_valid), 64'd1);
            check("drain_awaddr", axi_a.awaddr, 64'h100 + 64'(8 * j));
            check("drain_w_valid", 64'(axi_a.w_data_request_valid), 64'd1);
            check("drain_wdata", axi_a.wdata, 64'(j));
            check("drain_wstrb", 64'(axi_a.wstrb), 64'(8'h01 << j));
            if (j == 0) check("drain_ready_before_pop", 64'(mem_a.w_request_ready), 64'd0);
            if (j == 1) check("drain_ready_after_pop", 64'(mem_a.w_request_ready), 64'd1);
            step();
        end
        #1;
        check("drain_aw_empty", 64'(axi_a.w_addr_request_valid), 64'd0);
        check("drain_w_empty", 64'(axi_a.w_data_request_valid), 64'd0);
        axi_a.w_addr_request_ready = 1'b0;
        axi_a.w_data_request_ready = 1'b0;
        for (int i = 4; i < 6; i++) begin
            drive_wr_a(64'h100 + 64'(8 * i), 64'(i), 8'h01 << i);
            #1;
            check("rest_ready", 64'(mem_a.w_request_ready), 64'd1);
            step();
        end
        mem_a.w_request_valid = 1'b0;
        axi_a.w_addr_request_ready = 1'b1;
        axi_a.w_data_request_ready = 1'b1;
        for (int j = 4; j < 6; j++) begin
            #1;
            check("rest_awaddr", axi_a.awaddr, 64'h100 + 64'(8 * j));
            check("rest_wdata", axi_a.wdata, 64'(j));
            step();
        end
        #1;
        check("rest_wr_cnt", 64'(dut_a.wr_cnt_q), 64'd6);
        axi_a.w_reply_valid = 1'b1;
        axi_a.bresp = 2'b10;
        mem_a.w_reply_ready = 1'b1;
        #1;
        check("b_pass_valid", 64'(mem_a.w_reply_valid), 64'd1);
        check("b_pass_bresp", 64'(mem_a.bresp), 64'd2);
        check("b_pass_ready", 64'(axi_a.w_reply_ready), 64'd1);
        step(6);
        axi_a.w_reply_valid = 1'b0;
        axi_a.bresp = 2'b00;
        mem_a.w_reply_ready = 1'b0;
        #1;
        check("b_wr_cnt_zero", 64'(dut_a.wr_cnt_q), 64'd0);
        check("b_no_err", 64'(err_a), 64'd0);

        // Skewed AW/W: AW ready high, W ready held low for 5 cycles.
        axi_a.w_addr_request_ready = 1'b1;
        axi_a.w_data_request_ready = 1'b0;
        drive_wr_a(64'h200, 64'hA0, 8'hFF);
        step();
        drive_wr_a(64'h208, 64'hA1, 8'hFF);
        step();
        mem_a.w_request_valid = 1'b0;
        #1;
        check("skew_aw_second", axi_a.awaddr, 64'h208);
        check("skew_w_first", axi_a.wdata, 64'hA0);
        step();
        #1;
        check("skew_aw_done", 64'(axi_a.w_addr_request_valid), 64'd0);
        check("skew_w_waiting", 64'(axi_a.w_data_request_valid), 64'd1);
        step(3);
        #1;
        check("skew_w_stable", axi_a.wdata, 64'hA0);
        axi_a.w_data_request_ready = 1'b1;
        step();
        #1;
        check("skew_w_second", axi_a.wdata, 64'hA1);
        step();
        #1;
        check("skew_w_done", 64'(axi_a.w_data_request_valid), 64'd0);
        axi_a.w_reply_valid = 1'b1;
        mem_a.w_reply_ready = 1'b1;
        step(2);
        axi_a.w_reply_valid = 1'b0;
        mem_a.w_reply_ready = 1'b0;
        #1;
        check("skew_wr_cnt", 64'(dut_a.wr_cnt_q), 64'd0);

        // Read-after-write ordering on dut_a.
        drive_wr_a(64'h300, 64'h55, 8'hFF);
        step();
        mem_a.w_request_valid = 1'b0;
        mem_a.r_request_valid = 1'b1;
        mem_a.raddr = 64'h400;
        axi_a.r_request_ready = 1'b1;
        #1;
        check("raw_ar_held", 64'(axi_a.r_request_valid), 64'd0);
        check("raw_rd_ready_held", 64'(mem_a.r_request_ready), 64'd0);
        step(2);
        axi_a.w_reply_valid = 1'b1;
        mem_a.w_reply_ready = 1'b1;
        #1;
        check("raw_ar_held_b_cycle", 64'(axi_a.r_request_valid), 64'd0);
        step();
        axi_a.w_reply_valid = 1'b0;
        mem_a.w_reply_ready = 1'b0;
        #1;
        check("raw_ar_issue", 64'(axi_a.r_request_valid), 64'd1);
        check("raw_araddr", axi_a.araddr, 64'h400);
        check("raw_rd_ready", 64'(mem_a.r_request_ready), 64'd1);
        step();
        mem_a.r_request_valid = 1'b0;
        #1;
        check("raw_rd_cnt", 64'(dut_a.rd_cnt_q), 64'd1);
        axi_a.r_reply_valid = 1'b1;
        axi_a.rdata = 64'hDEAD_BEEF_0123_4567;
        axi_a.rresp = 2'b01;
        mem_a.r_reply_ready = 1'b1;
        #1;
        check("r_pass_valid", 64'(mem_a.r_reply_valid), 64'd1);
        check("r_pass_rdata", mem_a.rdata, 64'hDEAD_BEEF_0123_4567);
        check("r_pass_rresp", 64'(mem_a.rresp), 64'd1);
        step();
        axi_a.r_reply_valid = 1'b0;
        mem_a.r_reply_ready = 1'b0;
        #1;
        check("r_rd_cnt_zero", 64'(dut_a.rd_cnt_q), 64'd0);
        check("r_no_err", 64'(err_a), 64'd0);

        // Outstanding write limit on dut_b (MAX_WR_OUT=2).
        axi_b.w_addr_request_ready = 1'b1;
        axi_b.w_data_request_ready = 1'b1;
        drive_wr_b(64'h500, 64'd1);
        #1;
        check("lim_ready_0", 64'(mem_b.w_request_ready), 64'd1);
        step();
        drive_wr_b(64'h508, 64'd2);
        step();
        drive_wr_b(64'h510, 64'd3);
        #1;
        check("lim_stall", 64'(mem_b.w_request_ready), 64'd0);
        check("lim_cnt_2", 64'(dut_b.wr_cnt_q), 64'd2);
        step(2);
        #1;
        check("lim_still_stall", 64'(mem_b.w_request_ready), 64'd0);
        axi_b.w_reply_valid = 1'b1;
        mem_b.w_reply_ready = 1'b1;
        step();
        #1;
        check("lim_reopen", 64'(mem_b.w_request_ready), 64'd1);
        check("lim_cnt_1", 64'(dut_b.wr_cnt_q), 64'd1);
        step();
        axi_b.w_reply_valid = 1'b0;
        mem_b.w_reply_ready = 1'b0;
        #1;
        check("lim_simul_cnt", 64'(dut_b.wr_cnt_q), 64'd1);
        check("lim_simul_ready", 64'(mem_b.w_request_ready), 64'd1);
        drive_wr_b(64'h518, 64'd4);
        step();
        mem_b.w_request_valid = 1'b0;
        #1;
        check("lim_refull_cnt", 64'(dut_b.wr_cnt_q), 64'd2);
        check("lim_refull_ready", 64'(mem_b.w_request_ready), 64'd0);

        // Reads independent of writes on dut_b, up to MAX_RD_OUT=4.
        mem_b.r_request_valid = 1'b1;
        mem_b.raddr = 64'h600;
        axi_b.r_request_ready = 1'b1;
        #1;
        check("noraw_ar_issue", 64'(axi_b.r_request_valid), 64'd1);
        check("noraw_araddr", axi_b.araddr, 64'h600);
        check("noraw_rd_ready", 64'(mem_b.r_request_ready), 64'd1);
        step(4);
        #1;
        check("rdlim_cnt", 64'(dut_b.rd_cnt_q), 64'd4);
        check("rdlim_ar_gated", 64'(axi_b.r_request_valid), 64'd0);
        check("rdlim_ready_gated", 64'(mem_b.r_request_ready), 64'd0);
        mem_b.r_request_valid = 1'b0;

        // Underflow after reset.
        idle_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("uf_pre_err_a", 64'(err_a), 64'd0);
        check("uf_pre_err_b", 64'(err_b), 64'd0);
        check("uf_pre_cnt_b", 64'(dut_b.wr_cnt_q), 64'd0);
        axi_a.w_reply_valid = 1'b1;
        mem_a.w_reply_ready = 1'b1;
        step();
        axi_a.w_reply_valid = 1'b0;
        mem_a.w_reply_ready = 1'b0;
        #1;
        check("uf_b_err", 64'(err_a), 64'd1);
        check("uf_b_cnt", 64'(dut_a.wr_cnt_q), 64'd0);
        check("uf_b_other_clean", 64'(err_b), 64'd0);
        axi_b.r_reply_valid = 1'b1;
        mem_b.r_reply_ready = 1'b1;
        step();
        axi_b.r_reply_valid = 1'b0;
        mem_b.r_reply_ready = 1'b0;
        #1;
        check("uf_r_err", 64'(err_b), 64'd1);
        check("uf_r_cnt", 64'(dut_b.rd_cnt_q), 64'd0);
        step(3);
        #1;
        check("uf_hold_a", 64'(err_a), 64'd1);
        check("uf_hold_b", 64'(err_b), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("uf_clear_a", 64'(err_a), 64'd0);
        check("uf_clear_b", 64'(err_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
